// File: rtl/jtoutrun_subbridge.sv
// Bridges main CPU accesses in the sub CPU window onto the sub CPU bus:
// requests the bus, waits for grant and data, then returns DTACK to the main CPU.
module jtoutrun_subbridge #(
  parameter int SETTLE = 2,
  parameter int TOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cen,
  input  logic        win_cs,
  input  logic [19:1] cpu_A,
  input  logic        cpu_ASn,
  input  logic [1:0]  cpu_dsn,
  input  logic        cpu_rnw,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        win_ok,
  output logic        win_err,
  output logic        sub_br,
  output logic [19:1] sub_A,
  output logic [1:0]  sub_dsn,
  output logic        sub_rnw,
  output logic [15:0] sub_dout,
  input  logic [15:0] sub_din,
  input  logic        sub_ok
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_GRANT, ST_SETTLE, ST_DATA, ST_ACK, ST_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  tout_q, tout_d;
  logic        err_q, err_d;
  logic [15:0] din_q, din_d;
  logic [19:1] a_q, a_d;
  logic [1:0]  dsn_q, dsn_d;
  logic        rnw_q, rnw_d;
  logic [15:0] dout_q, dout_d;
  logic        start;

  assign start = win_cs & ~cpu_ASn & cpu_cen;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    err_d   = err_q;
    din_d   = din_q;
    a_d     = a_q;
    dsn_d   = dsn_q;
    rnw_d   = rnw_q;
    dout_d  = dout_q;
    case (state_q)
      // RELEASE accepts a pending request directly so that back-to-back
      // accesses drop sub_br for a single clock only.
      ST_IDLE, ST_RELEASE: begin
        state_d = ST_IDLE;
        if (start) begin
          a_d     = cpu_A;
          dsn_d   = cpu_dsn;
          rnw_d   = cpu_rnw;
          dout_d  = cpu_dout;
          tout_d  = 8'd0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (cpu_ASn) begin
          state_d = ST_RELEASE;
        end else if (sub_ok) begin
          cnt_d   = 3'(SETTLE);
          state_d = ST_SETTLE;
        end else if (tout_q == 8'(TOUT)) begin
          err_d   = 1'b1;
          din_d   = 16'hFFFF;
          state_d = ST_ACK;
        end else begin
          tout_d = tout_q + 8'd1;
        end
      end
      // sub_ok may still reflect the pre-grant bus here, so it is ignored
      ST_SETTLE: begin
        if (cpu_ASn) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            tout_d  = 8'd0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cpu_ASn) begin
          state_d = ST_RELEASE;
        end else if (sub_ok) begin
          if (rnw_q) din_d = sub_din;
          state_d = ST_ACK;
        end else if (tout_q == 8'(TOUT)) begin
          err_d   = 1'b1;
          din_d   = 16'hFFFF;
          state_d = ST_ACK;
        end else begin
          tout_d = tout_q + 8'd1;
        end
      end
      ST_ACK: begin
        if (cpu_ASn) state_d = ST_RELEASE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      tout_q  <= 8'd0;
      err_q   <= 1'b0;
      din_q   <= 16'd0;
      a_q     <= '0;
      dsn_q   <= 2'b11;
      rnw_q   <= 1'b1;
      dout_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
      err_q   <= err_d;
      din_q   <= din_d;
      a_q     <= a_d;
      dsn_q   <= dsn_d;
      rnw_q   <= rnw_d;
      dout_q  <= dout_d;
    end
  end

  assign sub_br   = (state_q == ST_GRANT) || (state_q == ST_SETTLE) ||
                    (state_q == ST_DATA)  || (state_q == ST_ACK);
  assign win_ok   = (state_q == ST_ACK);
  assign win_err  = err_q;
  assign cpu_din  = din_q;
  assign sub_A    = a_q;
  assign sub_dsn  = dsn_q;
  assign sub_rnw  = rnw_q;
  assign sub_dout = dout_q;

endmodule

// File: tb/tb_jtoutrun_subbridge.sv
// Self-checking bench for jtoutrun_subbridge: directed and randomized accesses
// compared against a latency/data model derived from the bridge's behaviour.
module tb_jtoutrun_subbridge;
  localparam int SETTLE_M = 2;
  localparam int TOUT_M   = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_cen = 1'b0;
  logic        win_cs = 1'b0;
  logic [19:1] cpu_A = '0;
  logic        cpu_ASn = 1'b1;
  logic [1:0]  cpu_dsn = 2'b11;
  logic        cpu_rnw = 1'b1;
  logic [15:0] cpu_dout = '0;
  logic [15:0] cpu_din;
  logic        win_ok, win_err, sub_br, sub_rnw;
  logic [19:1] sub_A;
  logic [1:0]  sub_dsn;
  logic [15:0] sub_dout;
  logic [15:0] sub_din = '0;
  logic        sub_ok = 1'b0;

  int checks = 0;
  int errors = 0;
  bit pat [0:599];
  logic [15:0] m_din = 16'd0;
  bit          m_err = 1'b0;

  jtoutrun_subbridge #(.SETTLE(SETTLE_M), .TOUT(TOUT_M)) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .win_cs(win_cs), .cpu_A(cpu_A),
    .cpu_ASn(cpu_ASn), .cpu_dsn(cpu_dsn), .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .win_ok(win_ok), .win_err(win_err), .sub_br(sub_br),
    .sub_A(sub_A), .sub_dsn(sub_dsn), .sub_rnw(sub_rnw), .sub_dout(sub_dout),
    .sub_din(sub_din), .sub_ok(sub_ok)
  );

  always #5 clk = ~clk;

  // pat[i] is the sub_ok level seen at edge i, edge 0 being the request edge.
  // Grant is taken at the first high edge from 1 on; after SETTLE masked
  // edges the first high edge completes the access; each wait is capped at
  // TOUT+1 edges.
  function automatic void model(output int ack, output bit err);
    int g, s;
    g = -1;
    ack = -1;
    for (int i = 1; i <= TOUT_M + 1; i++) if (g < 0 && pat[i]) g = i;
    if (g < 0) begin
      ack = TOUT_M + 1;
      err = 1'b1;
    end else begin
      s = g + SETTLE_M;
      for (int j = s + 1; j <= s + 1 + TOUT_M; j++) if (ack < 0 && pat[j]) ack = j;
      if (ack < 0) begin
        ack = s + 1 + TOUT_M;
        err = 1'b1;
      end else err = 1'b0;
    end
  endfunction

  task automatic do_access(input logic rnw, input logic [19:1] addr, input logic [1:0] dsn,
                           input logic [15:0] dout, input logic [15:0] sdin, input int nocen,
                           input bit b2b);
    int ack;
    bit err;
    model(ack, err);
    win_cs = 1'b1; cpu_A = addr; cpu_dsn = dsn; cpu_rnw = rnw; cpu_dout = dout;
    cpu_ASn = 1'b0; sub_din = sdin; sub_ok = 1'b0; cpu_cen = 1'b0;
    for (int k = 0; k < nocen; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sub_br !== 1'b0) begin errors++; $display("FAIL br_no_cen: got %b expected 0", sub_br); end
      @(negedge clk);
    end
    cpu_cen = 1'b1;
    sub_ok = pat[0];
    for (int i = 0; i <= ack; i++) begin
      @(posedge clk); #1;
      checks++;
      if (sub_br !== 1'b1 || win_ok !== (i == ack)) begin
        errors++;
        $display("FAIL handshake edge %0d: br=%b ok=%b expected br=1 ok=%b", i, sub_br, win_ok, i == ack);
      end
      checks++;
      if (sub_A !== addr || sub_dsn !== dsn || sub_rnw !== rnw || sub_dout !== dout) begin
        errors++;
        $display("FAIL sub_bus edge %0d: got %h/%b/%b/%h expected %h/%b/%b/%h",
                 i, sub_A, sub_dsn, sub_rnw, sub_dout, addr, dsn, rnw, dout);
      end
      @(negedge clk);
      cpu_cen = 1'($urandom_range(0, 1));
      sub_ok = pat[i + 1];
    end
    if (err) m_din = 16'hFFFF;
    else if (rnw) m_din = sdin;
    m_err = m_err | err;
    checks++;
    if (cpu_din !== m_din || win_err !== m_err) begin
      errors++;
      $display("FAIL result: din=%h err=%b expected din=%h err=%b", cpu_din, win_err, m_din, m_err);
    end
    for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
      @(posedge clk); #1;
      checks++;
      if (win_ok !== 1'b1) begin errors++; $display("FAIL ack_hold: got %b expected 1", win_ok); end
      @(negedge clk);
    end
    cpu_ASn = 1'b1; win_cs = 1'b0; sub_ok = 1'b0; cpu_cen = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sub_br !== 1'b0 || win_ok !== 1'b0) begin
      errors++;
      $display("FAIL release: br=%b ok=%b expected 0/0", sub_br, win_ok);
    end
    @(negedge clk);
    if (!b2b) begin
      @(posedge clk); #1;
      checks++;
      if (sub_br !== 1'b0) begin errors++; $display("FAIL idle_br: got %b expected 0", sub_br); end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (sub_br !== 1'b0 || win_ok !== 1'b0 || win_err !== 1'b0 || cpu_din !== 16'd0 ||
        sub_A !== 19'd0 || sub_dsn !== 2'b11 || sub_rnw !== 1'b1 || sub_dout !== 16'd0) begin
      errors++;
      $display("FAIL %s: br=%b ok=%b err=%b din=%h A=%h dsn=%b rnw=%b dout=%h expected reset values",
               tag, sub_br, win_ok, win_err, cpu_din, sub_A, sub_dsn, sub_rnw, sub_dout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
    m_din = 16'd0; m_err = 1'b0;
  endtask

  task automatic test_read();
    for (int i = 0; i < 600; i++) pat[i] = (i >= 3 && i <= 5) || (i >= 8);
    do_access(1'b1, 19'h30000, 2'b00, 16'h0000, 16'hA55A, 0, 1'b0);
  endtask

  task automatic test_write();
    for (int i = 0; i < 600; i++) pat[i] = 1'b1;
    do_access(1'b0, 19'h30002, 2'b10, 16'h1234, 16'hBEEF, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 600; i++) pat[i] = ($urandom_range(0, 3) != 0);
      do_access(1'($urandom_range(0, 1)), 19'($urandom), 2'($urandom), 16'($urandom),
                16'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 600; i++) pat[i] = (i >= 2);
    do_access(1'b1, 19'h00100, 2'b00, 16'h0, 16'h1111, 0, 1'b1);
    do_access(1'b1, 19'h00101, 2'b00, 16'h0, 16'h2222, 0, 1'b0);
  endtask

  task automatic test_abort();
    win_cs = 1'b1; cpu_A = 19'h12345; cpu_dsn = 2'b01; cpu_rnw = 1'b1; cpu_dout = 16'h0;
    cpu_ASn = 1'b0; cpu_cen = 1'b1; sub_ok = 1'b1; sub_din = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (win_ok !== 1'b0 || sub_br !== (i < 2)) begin
        errors++;
        $display("FAIL abort edge %0d: ok=%b br=%b expected 0/%b", i, win_ok, sub_br, i < 2);
      end
      @(negedge clk);
      if (i == 1) begin cpu_ASn = 1'b1; win_cs = 1'b0; end
    end
    checks++;
    if (cpu_din !== m_din) begin errors++; $display("FAIL abort_din: got %h expected %h", cpu_din, m_din); end
    sub_ok = 1'b0;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 600; i++) pat[i] = 1'b0;
    do_access(1'b1, 19'h40000, 2'b00, 16'h0, 16'h5555, 0, 1'b0);
    for (int i = 0; i < 600; i++) pat[i] = (i == 1);
    do_access(1'b0, 19'h40001, 2'b11, 16'h9999, 16'h5555, 0, 1'b0);
    for (int i = 0; i < 600; i++) pat[i] = 1'b1;
    do_access(1'b1, 19'h40002, 2'b00, 16'h0, 16'h0F0F, 0, 1'b0);
  endtask

  task automatic test_reset_mid_data();
    win_cs = 1'b1; cpu_A = 19'h55555; cpu_dsn = 2'b00; cpu_rnw = 1'b0; cpu_dout = 16'hCAFE;
    cpu_ASn = 1'b0; cpu_cen = 1'b1; sub_ok = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      sub_ok = (i == 0);
    end
    checks++;
    if (sub_br !== 1'b1 || win_ok !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: br=%b ok=%b expected 1/0", sub_br, win_ok);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("reset_mid_data");
    @(negedge clk);
    rst = 1'b1; cpu_ASn = 1'b1; win_cs = 1'b0; sub_ok = 1'b0;
    m_din = 16'd0; m_err = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("after_reset");
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_abort();
    test_random();
    test_timeout();
    test_reset_mid_data();
    test_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
